bit_plane_serializer: RTL

- Producer side of the bit-serial SMAC datapath: accepts a vector of M parallel N-bit operands and emits one M-bit bit-plane per cycle, LSB plane first.
- Output plane feeds the popcount adder tree's in_ba input; msb_a drives its MSB_a sign input.
- On the sign plane the adder subtracts instead of adding, completing the two's-complement weighting downstream.
- Valid/ready handshake on both sides; the downstream shift-accumulator may stall the stream.

---
 rtl/bit_plane_serializer_if.sv | 40 ++++
 rtl/bit_plane_serializer.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/bit_plane_serializer_if.sv
// ---------------------------------------------------------------------------
// bit_plane_serializer_if
//   Handshake bundle between an operand source, the bit-plane serializer and
//   the popcount adder tree / shift-accumulator downstream.
//
//   Input stream : in_valid, in_ready, in_data (M lanes x N bits), in_signed
//   Output stream: out_valid, out_ready, out_plane (M bits), out_msb_a,
//                  out_last, out_bit_idx
//
//   modport master : environment side (drives operands, consumes planes)
//   modport slave  : serializer side
// ---------------------------------------------------------------------------
interface bit_plane_serializer_if #(
    parameter int M = 16,
    parameter int N = 8
);
    localparam int IDX_W = $clog2(N);

    logic             in_valid;
    logic             in_ready;
    logic [M*N-1:0]   in_data;
    logic             in_signed;

    logic             out_valid;
    logic             out_ready;
    logic [M-1:0]     out_plane;
    logic             out_msb_a;
    logic             out_last;
    logic [IDX_W-1:0] out_bit_idx;

    modport master (
        output in_valid, in_data, in_signed, out_ready,
        input  in_ready, out_valid, out_plane, out_msb_a, out_last, out_bit_idx
    );

    modport slave (
        input  in_valid, in_data, in_signed, out_ready,
        output in_ready, out_valid, out_plane, out_msb_a, out_last, out_bit_idx
    );
endinterface

// File: rtl/bit_plane_serializer.sv
// ---------------------------------------------------------------------------
// bit_plane_serializer
//   Producer side of the bit-serial SMAC datapath. Accepts a vector of M
//   parallel N-bit operands and emits one M-bit bit-plane per cycle, LSB
//   plane first. out_msb_a flags the sign plane of a signed vector so the
//   downstream adder subtracts it, completing two's-complement weighting.
//
//   Ports:
//     clk  - clock
//     rst  - synchronous active-high reset (aborts any vector in flight)
//     bus  - bit_plane_serializer_if.slave
//              in_valid/in_ready/in_data/in_signed   : operand vector input
//              out_valid/out_ready/out_plane/out_msb_a/
//              out_last/out_bit_idx                  : bit-plane output
//
//   Optional feature (macro SMAC_SERIALIZER_PRELOAD_EN):
//     Adds a one-entry preload buffer so a new vector can be accepted while
//     the current one is shifting out, giving back-to-back vectors with no
//     idle cycle. Without the macro there is one idle cycle per vector.
// ---------------------------------------------------------------------------
module bit_plane_serializer #(
    parameter int M = 16,
    parameter int N = 8
) (
    input logic                   clk,
    input logic                   rst,
    bit_plane_serializer_if.slave bus
);
    localparam int IDX_W = $clog2(N);

    typedef enum logic [0:0] {IDLE, SHIFT} state_t;

    state_t           state_q, state_d;
    logic [M*N-1:0]   work_q, work_d;
    logic             signed_q, signed_d;
    logic [IDX_W-1:0] bit_idx_q, bit_idx_d;

`ifdef SMAC_SERIALIZER_PRELOAD_EN
    logic [M*N-1:0]   pre_data_q, pre_data_d;
    logic             pre_signed_q, pre_signed_d;
    logic             pre_full_q, pre_full_d;
`endif

    logic shifting;
    logic last_plane;
    logic accept;
    logic xfer;

    // Gather bit idx of every lane into one plane.
    function automatic logic [M-1:0] extract_plane(input logic [M*N-1:0] v,
                                                   input logic [IDX_W-1:0] idx);
        logic [M-1:0] p;
        p = '0;
        for (int i = 0; i < M; i++) begin
            p[i] = v[i*N + int'(idx)];
        end
        return p;
    endfunction

    assign shifting   = (state_q == SHIFT);
    assign last_plane = (bit_idx_q == IDX_W'(N-1));

    // Outputs depend only on registered state; in_* never reaches out_*.
    assign bus.out_valid   = shifting;
    assign bus.out_plane   = shifting ? extract_plane(work_q, bit_idx_q) : '0;
    assign bus.out_last    = shifting & last_plane;
    assign bus.out_msb_a   = shifting & last_plane & signed_q;
    assign bus.out_bit_idx = bit_idx_q;

`ifdef SMAC_SERIALIZER_PRELOAD_EN
    assign bus.in_ready = ~rst & ~pre_full_q;
`else
    assign bus.in_ready = ~rst & ~shifting;
`endif

    assign accept = bus.in_valid & bus.in_ready;
    assign xfer   = shifting & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        work_d    = work_q;
        signed_d  = signed_q;
        bit_idx_d = bit_idx_q;
`ifdef SMAC_SERIALIZER_PRELOAD_EN
        pre_data_d   = pre_data_q;
        pre_signed_d = pre_signed_q;
        pre_full_d   = pre_full_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    work_d    = bus.in_data;
                    signed_d  = bus.in_signed;
                    bit_idx_d = '0;
                    state_d   = SHIFT;
                end
            end
            SHIFT: begin
`ifdef SMAC_SERIALIZER_PRELOAD_EN
                // Park a vector accepted mid-stream; the last-plane branch
                // below may instead route it straight into work.
                if (accept) begin
                    pre_data_d   = bus.in_data;
                    pre_signed_d = bus.in_signed;
                    pre_full_d   = 1'b1;
                end
`endif
                if (xfer) begin
                    if (!last_plane) begin
                        bit_idx_d = bit_idx_q + IDX_W'(1);
                    end else begin
                        bit_idx_d = '0;
`ifdef SMAC_SERIALIZER_PRELOAD_EN
                        if (pre_full_q) begin
                            work_d     = pre_data_q;
                            signed_d   = pre_signed_q;
                            pre_full_d = 1'b0;
                        end else if (accept) begin
                            work_d     = bus.in_data;
                            signed_d   = bus.in_signed;
                            pre_full_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                        end
`else
                        state_d = IDLE;
`endif
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            work_q    <= '0;
            signed_q  <= 1'b0;
            bit_idx_q <= '0;
`ifdef SMAC_SERIALIZER_PRELOAD_EN
            pre_data_q   <= '0;
            pre_signed_q <= 1'b0;
            pre_full_q   <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            work_q    <= work_d;
            signed_q  <= signed_d;
            bit_idx_q <= bit_idx_d;
`ifdef SMAC_SERIALIZER_PRELOAD_EN
            pre_data_q   <= pre_data_d;
            pre_signed_q <= pre_signed_d;
            pre_full_q   <= pre_full_d;
`endif
        end
    end
endmodule
